// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO pair.
// Optional macro MULDIV_FAST_MULT_EN selects a single-cycle multiply; default is radix-2 iterative.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic             i_flush,
    input  logic             i_mthi,
    input  logic             i_mtlo,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] f_neg2(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               r_dz;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;

    logic               w_signed;
    logic               w_s1;
    logic               w_s2;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic               w_op2_zero;
    logic [2*WIDTH-1:0] w_acc_add;
    logic [WIDTH:0]     w_rem_shift;
    logic [WIDTH:0]     w_rem_diff;
    logic               w_rem_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] w_fast_prod;
`endif

    // Operand magnitudes, one iteration step and the final sign correction.
    always_comb begin
        w_signed   = ~i_op[0];
        w_s1       = w_signed & i_op1[WIDTH-1];
        w_s2       = w_signed & i_op2[WIDTH-1];
        w_op2_zero = (i_op2 == {WIDTH{1'b0}});
        if (w_s1) begin
            w_mag1 = f_neg(i_op1);
        end else begin
            w_mag1 = i_op1;
        end
        if (w_s2) begin
            w_mag2 = f_neg(i_op2);
        end else begin
            w_mag2 = i_op2;
        end
        if (r_b[0]) begin
            w_acc_add = r_acc + r_mcand;
        end else begin
            w_acc_add = r_acc;
        end
        // Borrow out of the (WIDTH+1)-bit subtract means the divisor did not fit.
        w_rem_shift = {r_rem, r_quo[WIDTH-1]};
        w_rem_diff  = w_rem_shift - {1'b0, r_b};
        w_rem_ge    = ~w_rem_diff[WIDTH];
        if (r_neg_lo) begin
            w_prod    = f_neg2(r_acc);
            w_quo_fix = f_neg(r_quo);
        end else begin
            w_prod    = r_acc;
            w_quo_fix = r_quo;
        end
        if (r_neg_hi) begin
            w_rem_fix = f_neg(r_rem);
        end else begin
            w_rem_fix = r_rem;
        end
`ifdef MULDIV_FAST_MULT_EN
        w_fast_prod = {{WIDTH{1'b0}}, r_mcand[WIDTH-1:0]} * {{WIDTH{1'b0}}, r_b};
`endif
    end

    // Sequencer FSM with HI/LO and all status outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= {WIDTH{1'b0}};
            r_lo       <= {WIDTH{1'b0}};
            r_cnt      <= {CW{1'b0}};
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_dz       <= 1'b0;
            r_acc      <= {(2*WIDTH){1'b0}};
            r_mcand    <= {(2*WIDTH){1'b0}};
            r_b        <= {WIDTH{1'b0}};
            r_quo      <= {WIDTH{1'b0}};
            r_rem      <= {WIDTH{1'b0}};
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_flush) begin
                        r_is_div <= i_op[1];
                        r_neg_lo <= w_s1 ^ w_s2;
                        r_neg_hi <= i_op[1] ? w_s1 : (w_s1 ^ w_s2);
                        r_dz     <= i_op[1] & w_op2_zero;
                        r_cnt    <= {CW{1'b0}};
                        r_acc    <= {(2*WIDTH){1'b0}};
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag1};
                        r_b      <= w_mag2;
                        r_quo    <= w_mag1;
                        r_rem    <= {WIDTH{1'b0}};
                        r_busy   <= 1'b1;
                        // Divide-by-zero skips the iterations and reports from FIX.
                        if (i_op[1] && w_op2_zero) begin
                            r_state <= S_FIX;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end else if (!i_start) begin
                        if (i_mthi) begin
                            r_hi <= i_wdata;
                        end
                        if (i_mtlo) begin
                            r_lo <= i_wdata;
                        end
                    end
                end
                S_CALC: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_is_div) begin
                        if (w_rem_ge) begin
                            r_rem <= w_rem_diff[WIDTH-1:0];
                        end else begin
                            r_rem <= w_rem_shift[WIDTH-1:0];
                        end
                        r_quo <= {r_quo[WIDTH-2:0], w_rem_ge};
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CNT_LAST) begin
                            r_state <= S_FIX;
                        end
                    end else begin
`ifdef MULDIV_FAST_MULT_EN
                        r_acc   <= w_fast_prod;
                        r_state <= S_FIX;
`else
                        r_acc   <= w_acc_add;
                        r_mcand <= r_mcand << 1;
                        r_b     <= r_b >> 1;
                        r_cnt   <= r_cnt + CW'(1);
                        if (r_cnt == CNT_LAST) begin
                            r_state <= S_FIX;
                        end
`endif
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_dz    <= 1'b0;
                    if (!i_flush) begin
                        r_done <= 1'b1;
                        if (r_dz) begin
                            r_div_zero <= 1'b1;
                        end else if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_dz    <= 1'b0;
                end
            endcase
        end
    end

    assign o_hi       = r_hi;
    assign o_lo       = r_lo;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_div_zero = r_div_zero;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer owning the HI/LO register pair. Sits beside the combinational ALU in the EX stage: accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO, runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles, and raises `busy` so the hazard unit stalls MFHI/MFLO and further mul/div issue until the result lands.

## Interface
- WIDTH, 32, operand width; HI/LO are each WIDTH bits; iteration count = WIDTH
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- start  in  1  issue request, sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- op1  in  WIDTH  rs value (multiplicand / dividend)
- op2  in  WIDTH  rt value (multiplier / divisor)
- flush  in  1  abort in-flight operation (exception/branch kill)
- mthi  in  1  write `wdata` to HI
- mtlo  in  1  write `wdata` to LO
- wdata  in  WIDTH  MTHI/MTLO data
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, HI/LO just updated or divide-by-zero reported
- div_zero  out  1  one-cycle pulse with `done` when DIV/DIVU has op2 == 0

## Operation
- States: IDLE, CALC, FIX. Reset: state IDLE; hi, lo, done, div_zero, counter, accumulators = 0.
- IDLE + start: latch op, magnitudes of op1/op2 (signed ops take two's-complement abs), result signs; counter = 0; -> CALC. start ignored outside IDLE.
- DIV/DIVU with op2 == 0 at start: no CALC; next edge -> IDLE, done = div_zero = 1, hi/lo unchanged.
- CALC multiply: 2*WIDTH-bit accumulator; per cycle add shifted multiplicand if multiplier LSB set, shift multiplier right.
- CALC divide: restoring; per cycle shift remainder left with next dividend bit, subtract divisor if non-negative, quotient bit = 1.
- CALC: counter increments each cycle; at counter == WIDTH-1 -> FIX.
- FIX: signed mult negates 64-bit product if signs differ; signed div negates quotient if signs differ, remainder takes dividend sign. hi = upper/remainder, lo = lower/quotient; done = 1; -> IDLE.
- 0x80000000 / -1 (DIV): lo = 0x80000000, hi = 0, no trap.
- mthi/mtlo: honoured only in IDLE and only when start is low (start wins); both may assert together. Ignored when busy.
- flush in CALC or FIX: -> IDLE next edge, hi/lo unchanged, no done. flush in IDLE with start: start dropped.
- Reset mid-operation: immediate return to reset values.

## Timing
- Start sampled at edge E0; E1..E32 iterate (WIDTH = 32); E33 FIX writes hi/lo; done high for the cycle after E33.
- busy high from after E0 through the cycle before done; busy low in the done cycle, so a new start may coincide with done.
- Divide-by-zero: done/div_zero high the cycle after E1.
- mthi/mtlo: hi/lo updated at the next edge; readable the following cycle.
- done and div_zero are registered, never combinational.

## Configuration
- MULDIV_FAST_MULT_EN defined: MULT/MULTU use a single-cycle `*` product in CALC (one CALC cycle, then FIX); done after E2. Divide unchanged.
- Undefined: multiply is iterative, WIDTH CALC cycles, timing as above.

## Test plan
- MULT op1 = 0xFFFFFFFE (-2), op2 = 3 -> done after E33; hi = 0xFFFFFFFF, lo = 0xFFFFFFFA; busy high for 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
- DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU 100 / 7 -> lo = 14, hi = 2.
- DIV 5 / 0 -> done and div_zero high the cycle after E1; hi/lo retain prior 0x1234/0x5678.
- MTHI 0xAAAA with start low in IDLE -> hi = 0xAAAA next cycle; MTLO during busy -> lo unchanged.
- Start DIVU, flush at E10 -> IDLE at E11, no done, hi/lo unchanged; a new start at E11 completes normally.
